// File: rtl/bdos_pkg.sv
// Shared types and constants for the CP/M BDOS console trap.
package bdos_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHAR     = 3'd1,
        ST_STR_REQ  = 3'd2,
        ST_STR_PUSH = 3'd3,
        ST_ERR      = 3'd4
    } state_e;

    localparam int unsigned CHAR_W = 8;

    localparam logic [7:0]  BDOS_PRINT_CHAR = 8'd2;
    localparam logic [7:0]  BDOS_PRINT_STR  = 8'd9;
    localparam logic [7:0]  BDOS_TERM_CHAR  = 8'h24;
    localparam logic [15:0] BDOS_TRAP_ADDR  = 16'h0005;
    localparam logic [15:0] BDOS_ERR_ADDR   = 16'h069F;

endpackage

// File: rtl/bdos_char_fifo.sv
// Character FIFO between the BDOS trap and the console sink.
// Ports: push_i/data_i/full_o write side, pop_i/empty_o/head_o read side.
// A push is accepted only when the FIFO is not full at the start of the
// cycle, even if a pop happens in the same cycle. No fall-through: the head
// becomes visible the cycle after a push into an empty FIFO.
module bdos_char_fifo
    import bdos_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = CHAR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    input  logic              pop_i,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok_c, pop_ok_c;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign head_o    = mem_q[rd_ptr_q];
    assign push_ok_c = push_i & ~full_o;
    assign pop_ok_c  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push_ok_c, pop_ok_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bdos_console_trap.sv
// CP/M BDOS console trap: services fn 2 / fn 9 on opcode fetches at TRAP_ADDR,
// freezes the CPU on a fetch of ERR_ADDR, and streams characters to a
// ready/valid console sink through bdos_char_fifo.
// Ports: clk/rst_n; CPU side m1_strobe, pc, reg_c, reg_de, cpu_hold;
// memory side mem_req/mem_addr/mem_ack/mem_rdata; sink side
// out_valid/out_data/out_ready; status err_hit, bad_call, str_ovf, m1_count.
module bdos_console_trap
    import bdos_pkg::*;
#(
    parameter int unsigned      ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] TRAP_ADDR = ADDR_W'(BDOS_TRAP_ADDR),
    parameter logic [ADDR_W-1:0] ERR_ADDR  = ADDR_W'(BDOS_ERR_ADDR),
    parameter int unsigned      FIFO_DEPTH = 16,
    parameter int unsigned      MAX_STR    = 256,
    parameter logic [7:0]       TERM_CHAR  = BDOS_TERM_CHAR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m1_strobe,
    input  logic [ADDR_W-1:0] pc,
    input  logic [7:0]        reg_c,
    input  logic [15:0]       reg_de,
    output logic              cpu_hold,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              err_hit,
    output logic              bad_call,
    output logic              str_ovf,
    output logic [31:0]       m1_count
);

    localparam int unsigned CNT_W = $clog2(MAX_STR + 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic [7:0]         byte_q, byte_d;
    logic               hold_q, hold_d;
    logic               mem_req_q, mem_req_d;
    logic               err_hit_q, err_hit_d;
    logic               bad_call_q, bad_call_d;
    logic               str_ovf_q, str_ovf_d;
    logic [31:0]        m1_count_q, m1_count_d;
    logic               push_c;
    logic               fifo_full_c, fifo_empty_c;

    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        err_hit_d  = err_hit_q;
        str_ovf_d  = str_ovf_q;
        bad_call_d = 1'b0;
        push_c     = 1'b0;
        m1_count_d = (m1_strobe && (m1_count_q != '1)) ? m1_count_q + 32'd1 : m1_count_q;

        unique case (state_q)
            ST_IDLE: begin
                // The error address is tested first so it wins if both match.
                if (m1_strobe && (pc == ERR_ADDR)) begin
                    err_hit_d = 1'b1;
                    state_d   = ST_ERR;
                end else if (m1_strobe && (pc == TRAP_ADDR)) begin
                    if (reg_c == BDOS_PRINT_CHAR) begin
                        byte_d  = reg_de[7:0];
                        state_d = ST_CHAR;
                    end else if (reg_c == BDOS_PRINT_STR) begin
                        ptr_d   = ADDR_W'(reg_de);
                        cnt_d   = '0;
                        state_d = ST_STR_REQ;
                    end else begin
                        bad_call_d = 1'b1;
                    end
                end
            end
            ST_CHAR: begin
                if (!fifo_full_c) begin
                    push_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_STR_REQ: begin
                if (mem_ack) begin
                    if (mem_rdata == TERM_CHAR) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_d  = mem_rdata;
                        state_d = ST_STR_PUSH;
                    end
                end
            end
            ST_STR_PUSH: begin
                if (!fifo_full_c) begin
                    push_c = 1'b1;
                    ptr_d  = ptr_q + ADDR_W'(1);
                    cnt_d  = cnt_inc_c;
                    if (cnt_inc_c == CNT_W'(MAX_STR)) begin
                        str_ovf_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_STR_REQ;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hold_d    = (state_d != ST_IDLE);
        mem_req_d = (state_d == ST_STR_REQ);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            byte_q     <= '0;
            hold_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            err_hit_q  <= 1'b0;
            bad_call_q <= 1'b0;
            str_ovf_q  <= 1'b0;
            m1_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            hold_q     <= hold_d;
            mem_req_q  <= mem_req_d;
            err_hit_q  <= err_hit_d;
            bad_call_q <= bad_call_d;
            str_ovf_q  <= str_ovf_d;
            m1_count_q <= m1_count_d;
        end
    end

    bdos_char_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (CHAR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .data_i  (byte_q),
        .full_o  (fifo_full_c),
        .pop_i   (out_ready),
        .empty_o (fifo_empty_c),
        .head_o  (out_data)
    );

    assign cpu_hold  = hold_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = ptr_q;
    assign out_valid = ~fifo_empty_c;
    assign err_hit   = err_hit_q;
    assign bad_call  = bad_call_q;
    assign str_ovf   = str_ovf_q;
    assign m1_count  = m1_count_q;

endmodule

// File: tb/tb_bdos_console_trap.sv
// Directed bench for bdos_console_trap: a table of single-trap vectors plus
// hand-written sequences for strings, wrap, back-pressure, overflow, error
// freeze and mid-operation reset.
module tb_bdos_console_trap;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m1_strobe;
    logic [15:0] pc;
    logic [7:0]  reg_c;
    logic [15:0] reg_de;
    logic        cpu_hold;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        err_hit;
    logic        bad_call;
    logic        str_ovf;
    logic [31:0] m1_count;

    int errors = 0;
    int checks = 0;
    int m1_sent = 0;

    logic [7:0]  tb_mem [0:65535];
    logic [15:0] rd_log [$];
    logic [7:0]  rx [$];

    always #5 clk = ~clk;

    bdos_console_trap dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m1_strobe (m1_strobe),
        .pc        (pc),
        .reg_c     (reg_c),
        .reg_de    (reg_de),
        .cpu_hold  (cpu_hold),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .err_hit   (err_hit),
        .bad_call  (bad_call),
        .str_ovf   (str_ovf),
        .m1_count  (m1_count)
    );

    // Memory responder: one-cycle ack per request, logs every read address.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_ack = 1'b0;
            end else if (mem_req && !mem_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = tb_mem[mem_addr];
                rd_log.push_back(mem_addr);
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // Console sink: a byte is taken at the next edge when valid & ready.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) rx.push_back(out_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] p, input logic [7:0] c, input logic [15:0] de);
        @(posedge clk);
        #1;
        m1_strobe = 1'b1;
        pc        = p;
        reg_c     = c;
        reg_de    = de;
        @(posedge clk);
        #1;
        m1_strobe = 1'b0;
        m1_sent++;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (cpu_hold && k < budget) begin
            settle();
            k++;
        end
        check(name, 32'(cpu_hold), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [7:0]  c;
        logic [15:0] de;
        int          exp_hold;
        int          exp_bad;
        int          exp_first_valid;
        int          exp_nbytes;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int hold_n, bad_n, first_v, nbad;

        vecs[0] = '{"fn2_A",     16'h0005, 8'h02, 16'h0041, 1, 0,  1, 1, 8'h41};
        vecs[1] = '{"fn2_hi_de", 16'h0005, 8'h02, 16'h1234, 1, 0,  1, 1, 8'h34};
        vecs[2] = '{"bad_c05",   16'h0005, 8'h05, 16'h0041, 0, 1, -1, 0, 8'h00};
        vecs[3] = '{"bad_c00",   16'h0005, 8'h00, 16'h0041, 0, 1, -1, 0, 8'h00};
        vecs[4] = '{"bad_c82",   16'h0005, 8'h82, 16'h0041, 0, 1, -1, 0, 8'h00};
        vecs[5] = '{"miss_pc6",  16'h0006, 8'h02, 16'h0041, 0, 0, -1, 0, 8'h00};
        vecs[6] = '{"miss_pc4",  16'h0004, 8'h09, 16'h0200, 0, 0, -1, 0, 8'h00};

        for (int i = 0; i < 65536; i++) tb_mem[i] = 8'h00;
        tb_mem[16'h0200] = 8'h4F;
        tb_mem[16'h0201] = 8'h4B;
        tb_mem[16'h0202] = 8'h24;
        tb_mem[16'hFFFF] = 8'h41;
        tb_mem[16'h0000] = 8'h24;
        for (int i = 0; i < 20; i++) tb_mem[16'h0300 + i] = 8'h61 + 8'(i);
        tb_mem[16'h0314] = 8'h24;
        for (int i = 0; i < 300; i++) tb_mem[16'h1000 + i] = 8'h5A;

        rst_n     = 1'b0;
        m1_strobe = 1'b0;
        pc        = 16'h0000;
        reg_c     = 8'h00;
        reg_de    = 16'h0000;
        out_ready = 1'b1;

        // Reset state.
        cycles(3);
        rst_n = 1'b1;
        settle();
        check("rst_hold", 32'(cpu_hold), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_flags", {29'd0, err_hit, bad_call, str_ovf}, 0);
        check("rst_m1_count", m1_count, 0);

        // Single-trap vector table.
        foreach (vecs[i]) begin
            rx.delete();
            pulse(vecs[i].pc, vecs[i].c, vecs[i].de);
            hold_n = 0; bad_n = 0; first_v = -1;
            for (int k = 0; k < 6; k++) begin
                settle();
                hold_n += int'(cpu_hold);
                bad_n  += int'(bad_call);
                if (out_valid && first_v < 0) first_v = k;
            end
            check({vecs[i].name, "_hold"}, 32'(hold_n), 32'(vecs[i].exp_hold));
            check({vecs[i].name, "_bad"}, 32'(bad_n), 32'(vecs[i].exp_bad));
            check({vecs[i].name, "_latency"}, 32'(first_v), 32'(vecs[i].exp_first_valid));
            check({vecs[i].name, "_nbytes"}, 32'(rx.size()), 32'(vecs[i].exp_nbytes));
            if (rx.size() > 0) check({vecs[i].name, "_byte"}, 32'(rx[0]), 32'(vecs[i].exp_byte));
        end
        check("m1_count_table", m1_count, 32'(m1_sent));

        // fn 9 "OK$" at 0200.
        rx.delete(); rd_log.delete();
        pulse(16'h0005, 8'h09, 16'h0200);
        hold_n = 1;
        while (cpu_hold && hold_n < 50) begin
            settle();
            if (cpu_hold) hold_n++;
        end
        check("ok_hold_cycles", 32'(hold_n), 32'd6);
        cycles(4); settle();
        check("ok_nreads", 32'(rd_log.size()), 32'd3);
        if (rd_log.size() == 3) begin
            check("ok_rd0", 32'(rd_log[0]), 32'h0200);
            check("ok_rd1", 32'(rd_log[1]), 32'h0201);
            check("ok_rd2", 32'(rd_log[2]), 32'h0202);
        end
        check("ok_nbytes", 32'(rx.size()), 32'd2);
        if (rx.size() == 2) check("ok_bytes", {16'd0, rx[0], rx[1]}, 32'h4F4B);

        // fn 9 pointer wrap from FFFF to 0000.
        rx.delete(); rd_log.delete();
        pulse(16'h0005, 8'h09, 16'hFFFF);
        wait_idle("wrap_timeout", 50);
        cycles(4); settle();
        check("wrap_nreads", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() == 2) check("wrap_rd1", 32'(rd_log[1]), 32'h0000);
        check("wrap_nbytes", 32'(rx.size()), 32'd1);
        if (rx.size() == 1) check("wrap_byte", 32'(rx[0]), 32'h41);

        // Back-pressure: 20-char string into a 16-deep FIFO.
        rx.delete(); rd_log.delete();
        out_ready = 1'b0;
        pulse(16'h0005, 8'h09, 16'h0300);
        cycles(100); settle();
        check("stall_hold", 32'(cpu_hold), 32'd1);
        check("stall_mem_req", 32'(mem_req), 32'd0);
        check("stall_nreads", 32'(rd_log.size()), 32'd17);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_rx_empty", 32'(rx.size()), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle("stall_timeout", 200);
        cycles(25); settle();
        check("stall_nbytes", 32'(rx.size()), 32'd20);
        nbad = 0;
        for (int i = 0; i < rx.size() && i < 20; i++)
            if (rx[i] !== 8'h61 + 8'(i)) nbad++;
        check("stall_order", 32'(nbad), 32'd0);
        check("stall_nreads_end", 32'(rd_log.size()), 32'd21);

        // Unterminated string aborts after MAX_STR characters.
        check("ovf_clear_before", 32'(str_ovf), 32'd0);
        rx.delete(); rd_log.delete();
        pulse(16'h0005, 8'h09, 16'h1000);
        wait_idle("ovf_timeout", 2000);
        cycles(5); settle();
        check("ovf_flag", 32'(str_ovf), 32'd1);
        check("ovf_nbytes", 32'(rx.size()), 32'd256);
        check("ovf_nreads", 32'(rd_log.size()), 32'd256);
        if (rd_log.size() > 0) check("ovf_last_rd", 32'(rd_log[rd_log.size()-1]), 32'h10FF);

        // Error address: sticky flag, frozen CPU, traps ignored, FIFO drains.
        rx.delete();
        out_ready = 1'b0;
        pulse(16'h0005, 8'h02, 16'h0058);
        wait_idle("err_pre_timeout", 20);
        pulse(16'h069F, 8'h02, 16'h0000);
        settle();
        check("err_flag", 32'(err_hit), 32'd1);
        check("err_hold", 32'(cpu_hold), 32'd1);
        pulse(16'h0005, 8'h02, 16'h0059);
        pulse(16'h0005, 8'h05, 16'h0000);
        cycles(4); settle();
        check("err_hold_stuck", 32'(cpu_hold), 32'd1);
        check("err_bad_ignored", 32'(bad_call), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cycles(6); settle();
        check("err_drain_n", 32'(rx.size()), 32'd1);
        if (rx.size() == 1) check("err_drain_byte", 32'(rx[0]), 32'h58);
        check("err_m1_count", m1_count, 32'(m1_sent));

        // Reset in the middle of a string clears everything at once.
        @(posedge clk); #1;
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        m1_sent = 0;
        out_ready = 1'b0;
        pulse(16'h0005, 8'h09, 16'h0300);
        cycles(5);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_flags", {29'd0, err_hit, bad_call, str_ovf}, 32'd0);
        check("midrst_m1_count", m1_count, 32'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3); settle();
        check("post_rst_idle", {30'd0, cpu_hold, mem_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
